// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, inst}
// packets with first-word fall-through, full back-pressure and mispredict flush.
module inst_queue #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     enq_valid,
   input  logic [WIDTH-1:0]         enq_data,
   output logic                     full,
   output logic                     deq_valid,
   output logic [WIDTH-1:0]         deq_data,
   input  logic                     deq_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      head, tail;
   logic             empty, enq_fire, deq_fire;

   // Status comes from the registered pointers only, so deq_ready never
   // reaches the full path.
   assign count     = tail - head;
   assign empty     = (head == tail);
   assign full      = (count == CNT_FULL);
   assign deq_valid = !empty;
   assign deq_data  = mem[head[AW-1:0]];
   assign enq_fire  = enq_valid && !full;
   assign deq_fire  = deq_valid && deq_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head     <= '0;
         tail     <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         head     <= '0;
         tail     <= '0;
         overflow <= 1'b0;
      end else begin
         if (enq_fire)
            tail <= tail + PTR_ONE;
         if (deq_fire)
            head <= head + PTR_ONE;
         if (enq_valid && full)
            overflow <= 1'b1;
      end
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (enq_fire && !flush)
         mem[tail[AW-1:0]] <= enq_data;
   end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=4): queue-based reference model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_inst_queue;
   localparam int DEPTH = 4;
   localparam int WIDTH = 64;

   logic             clk, rst, flush, enq_valid, deq_ready;
   logic [WIDTH-1:0] enq_data;
   logic             full, deq_valid, overflow;
   logic [WIDTH-1:0] deq_data;
   logic [2:0]       count;

   int total = 0;
   int bad   = 0;

   inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_data(enq_data), .full(full),
      .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready),
      .count(count), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", n, a, e);
      end
   endfunction

   // Reference model: a plain queue of packets plus the sticky flag.
   logic [WIDTH-1:0] mq[$];
   bit               movf;
   bit               m_full, m_dfire;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         movf = 1'b0;
      end else if (flush) begin
         mq.delete();
         movf = 1'b0;
      end else begin
         m_full  = (mq.size() == DEPTH);
         m_dfire = (mq.size() != 0) && deq_ready;
         if (enq_valid && m_full) movf = 1'b1;
         if (m_dfire) void'(mq.pop_front());
         if (enq_valid && !m_full) mq.push_back(enq_data);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("m_deq_valid", 64'(deq_valid), 64'(mq.size() != 0));
         chk("m_count",     64'(count),     64'(mq.size()));
         chk("m_full",      64'(full),      64'(mq.size() == DEPTH));
         chk("m_overflow",  64'(overflow),  64'(movf));
         if (mq.size() != 0) chk("m_deq_data", deq_data, mq[0]);
      end
   end

   // Drive one cycle's inputs right after a falling edge, return at the next one.
   task automatic cyc(input logic ev, input logic [63:0] d, input logic dr, input logic fl);
      enq_valid = ev; enq_data = d; deq_ready = dr; flush = fl;
      @(negedge clk);
   endtask

   function automatic logic [63:0] pkt(input logic [31:0] pc, input logic [31:0] inst);
      return {pc, inst};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_valid", 64'(deq_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Fill and drain
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, pkt(32'(4*i), 32'(32'h13 + 32'h80*i)), 1'b0, 1'b0);
         chk("fill_count", 64'(count), 64'(i+1));
      end
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_head", deq_data, 64'h00000000_00000013);
      for (int i = 0; i < 4; i++) begin
         chk("drain_data", deq_data, pkt(32'(4*i), 32'(32'h13 + 32'h80*i)));
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_valid", 64'(deq_valid), 64'd0);

      // Wrap-around streaming (pointers already past the first lap)
      cyc(1'b1, pkt(32'h100, 32'h1000), 1'b0, 1'b0);
      for (int i = 1; i < 10; i++) begin
         cyc(1'b1, pkt(32'(32'h100 + 4*i), 32'(32'h1000 + i)), 1'b1, 1'b0);
         chk("wrap_count", 64'(count), 64'd1);
         chk("wrap_data", deq_data, pkt(32'(32'h100 + 4*i), 32'(32'h1000 + i)));
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("wrap_empty", 64'(count), 64'd0);

      // Full with simultaneous dequeue: enqueue refused
      for (int i = 0; i < 4; i++) cyc(1'b1, pkt(32'h200 + 32'(i), 32'hA0 + 32'(i)), 1'b0, 1'b0);
      cyc(1'b1, pkt(32'h2FF, 32'hFF), 1'b1, 1'b0);
      chk("fd_count", 64'(count), 64'd3);
      chk("fd_ovf", 64'(overflow), 64'd1);
      chk("fd_full", 64'(full), 64'd0);
      chk("fd_head", deq_data, pkt(32'h201, 32'hA1));
      cyc(1'b1, pkt(32'h2FF, 32'hFF), 1'b0, 1'b0);
      chk("fd_count2", 64'(count), 64'd4);
      chk("fd_ovf_sticky", 64'(overflow), 64'd1);

      // Flush with concurrent enqueue
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("fl_pre", 64'(count), 64'd3);
      cyc(1'b1, pkt(32'h40, 32'h13), 1'b0, 1'b1);
      chk("fl_count", 64'(count), 64'd0);
      chk("fl_valid", 64'(deq_valid), 64'd0);
      chk("fl_ovf", 64'(overflow), 64'd0);
      chk("fl_full", 64'(full), 64'd0);
      cyc(1'b1, pkt(32'h80, 32'h93), 1'b0, 1'b0);
      chk("fl_pc", 64'(deq_data[63:32]), 64'h80);
      chk("fl_count2", 64'(count), 64'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Async reset mid-stream
      cyc(1'b1, pkt(32'h300, 32'h1), 1'b0, 1'b0);
      cyc(1'b1, pkt(32'h304, 32'h2), 1'b0, 1'b0);
      chk("ar_pre", 64'(count), 64'd2);
      #2 rst = 1'b0;
      #1;
      chk("ar_valid", 64'(deq_valid), 64'd0);
      chk("ar_count", 64'(count), 64'd0);
      chk("ar_full", 64'(full), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      cyc(1'b1, pkt(32'h308, 32'h3), 1'b0, 1'b0);
      chk("ar_post_valid", 64'(deq_valid), 64'd1);
      chk("ar_post_data", deq_data, pkt(32'h308, 32'h3));
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Dequeue on empty queue has no effect
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         chk("ed_count", 64'(count), 64'd0);
      end
      cyc(1'b1, pkt(32'h400, 32'h77), 1'b1, 1'b0);
      chk("ed_data", deq_data, pkt(32'h400, 32'h77));
      chk("ed_count2", 64'(count), 64'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("ed_final", 64'(count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
